// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_div_unit_pkg                                              |
// | Brief    : ALU control encodings (base + M extension), mul/div FSM state |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package mul_div_unit_pkg;

    typedef logic [4:0] alu_ctrl_t;

    localparam alu_ctrl_t c_alu_add    = 5'b00000;
    localparam alu_ctrl_t c_alu_sub    = 5'b00001;
    localparam alu_ctrl_t c_alu_sll    = 5'b00010;
    localparam alu_ctrl_t c_alu_slt    = 5'b00011;
    localparam alu_ctrl_t c_alu_sltu   = 5'b00100;
    localparam alu_ctrl_t c_alu_xor    = 5'b00101;
    localparam alu_ctrl_t c_alu_srl    = 5'b00110;
    localparam alu_ctrl_t c_alu_sra    = 5'b00111;
    localparam alu_ctrl_t c_alu_or     = 5'b01000;
    localparam alu_ctrl_t c_alu_and    = 5'b01001;
    localparam alu_ctrl_t c_alu_addw   = 5'b01010;
    localparam alu_ctrl_t c_alu_subw   = 5'b01011;
    localparam alu_ctrl_t c_alu_sllw   = 5'b01100;
    localparam alu_ctrl_t c_alu_srlw   = 5'b01101;
    localparam alu_ctrl_t c_alu_sraw   = 5'b01110;

    localparam alu_ctrl_t c_alu_mul    = 5'b01111;
    localparam alu_ctrl_t c_alu_mulh   = 5'b10000;
    localparam alu_ctrl_t c_alu_mulhsu = 5'b10001;
    localparam alu_ctrl_t c_alu_mulhu  = 5'b10010;
    localparam alu_ctrl_t c_alu_div    = 5'b10011;
    localparam alu_ctrl_t c_alu_divu   = 5'b10100;
    localparam alu_ctrl_t c_alu_rem    = 5'b10101;
    localparam alu_ctrl_t c_alu_remu   = 5'b10110;
    localparam alu_ctrl_t c_alu_mulw   = 5'b10111;
    localparam alu_ctrl_t c_alu_divw   = 5'b11000;
    localparam alu_ctrl_t c_alu_divuw  = 5'b11001;
    localparam alu_ctrl_t c_alu_remw   = 5'b11010;
    localparam alu_ctrl_t c_alu_remuw  = 5'b11011;

    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_prep = 2'd1,
        c_st_calc = 2'd2,
        c_st_done = 2'd3
    } md_state_e;

    localparam logic [6:0] c_iter_dword = 7'd64;
    localparam logic [6:0] c_iter_word  = 7'd32;

    function automatic logic op_is_legal(input alu_ctrl_t op);
        return (op >= c_alu_mul) && (op <= c_alu_remuw);
    endfunction

    function automatic logic op_is_word(input alu_ctrl_t op);
        return op inside {c_alu_mulw, c_alu_divw, c_alu_divuw, c_alu_remw, c_alu_remuw};
    endfunction

    function automatic logic op_is_div(input alu_ctrl_t op);
        return op inside {c_alu_div, c_alu_divu, c_alu_rem, c_alu_remu,
                          c_alu_divw, c_alu_divuw, c_alu_remw, c_alu_remuw};
    endfunction

    function automatic logic op_is_rem(input alu_ctrl_t op);
        return op inside {c_alu_rem, c_alu_remu, c_alu_remw, c_alu_remuw};
    endfunction

    function automatic logic op_signed_a(input alu_ctrl_t op);
        return op inside {c_alu_mulh, c_alu_mulhsu, c_alu_div, c_alu_rem, c_alu_divw, c_alu_remw};
    endfunction

    function automatic logic op_signed_b(input alu_ctrl_t op);
        return op inside {c_alu_mulh, c_alu_div, c_alu_rem, c_alu_divw, c_alu_remw};
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul_div_unit                                                  |
// | Brief    : Iterative radix-2 RV64 M-extension multiply/divide unit       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [4:0]  alu_control_i,
    input  logic [63:0] src1_i,
    input  logic [63:0] src2_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] result_o
);

    md_state_e    r_state;
    alu_ctrl_t    r_op;
    logic [63:0]  r_a;
    logic [63:0]  r_b;
    logic [127:0] r_acc;
    logic [6:0]   r_cnt;
    logic         r_neg;
    logic         r_done;
    logic [63:0]  r_result;

    logic         w_word, w_div, w_rem, w_sa, w_sb;
    logic [63:0]  w_a_ext, w_b_ext, w_mag_a, w_mag_b;
    logic         w_neg_a, w_neg_b, w_neg_res;
    logic         w_div_zero, w_ovf, w_fast;
    logic [63:0]  w_fast_result;
    logic [64:0]  w_mul_sum, w_div_part;
    logic [63:0]  w_div_diff;
    logic         w_div_ge;
    logic [127:0] w_acc_step, w_prod;
    logic [63:0]  w_quo64, w_rem64;
    logic [31:0]  w_quo32, w_rem32;
    logic [63:0]  w_quo_res, w_rem_res, w_final;
    logic [6:0]   w_cnt_dec;

    // Operand conditioning: extension, magnitude and fast-path detection
    always_comb begin
        w_word  = op_is_word(r_op);
        w_div   = op_is_div(r_op);
        w_rem   = op_is_rem(r_op);
        w_sa    = op_signed_a(r_op);
        w_sb    = op_signed_b(r_op);
        w_a_ext = w_word ? (w_sa ? sext32(r_a[31:0]) : {32'd0, r_a[31:0]}) : r_a;
        w_b_ext = w_word ? (w_sb ? sext32(r_b[31:0]) : {32'd0, r_b[31:0]}) : r_b;
        w_neg_a = w_sa && w_a_ext[63];
        w_neg_b = w_sb && w_b_ext[63];
        w_mag_a = w_neg_a ? (64'd0 - w_a_ext) : w_a_ext;
        w_mag_b = w_neg_b ? (64'd0 - w_b_ext) : w_b_ext;
        w_neg_res  = w_rem ? w_neg_a : (w_neg_a ^ w_neg_b);
        w_div_zero = w_div && (w_b_ext == 64'd0);
        w_ovf      = w_div && w_sa && (&w_b_ext) &&
                     (w_a_ext == (w_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        w_fast     = !op_is_legal(r_op) || w_div_zero || w_ovf;

        w_fast_result = 64'd0;
        if (w_div_zero) begin
            w_fast_result = w_rem ? (w_word ? sext32(r_a[31:0]) : r_a) : {64{1'b1}};
        end else if (w_ovf) begin
            w_fast_result = w_rem ? 64'd0 : w_a_ext;
        end
    end

    // One radix-2 step on the shared 128-bit register: {hi, lo}
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[127:64]} + (r_acc[0] ? {1'b0, r_b} : 65'd0);
        w_div_part = r_acc[127:63];
        w_div_ge   = (w_div_part >= {1'b0, r_b});
        w_div_diff = w_div_part[63:0] - r_b;
        if (w_div) begin
            w_acc_step = w_div_ge ? {w_div_diff, r_acc[62:0], 1'b1}
                                  : {w_div_part[63:0], r_acc[62:0], 1'b0};
        end else begin
            w_acc_step = {w_mul_sum, r_acc[63:1]};
        end
        w_cnt_dec = r_cnt - 7'd1;
    end

    // Sign correction and result selection from the final step
    always_comb begin
        w_prod    = r_neg ? (128'd0 - w_acc_step) : w_acc_step;
        w_quo64   = r_neg ? (64'd0 - w_acc_step[63:0])   : w_acc_step[63:0];
        w_rem64   = r_neg ? (64'd0 - w_acc_step[127:64]) : w_acc_step[127:64];
        w_quo32   = r_neg ? (32'd0 - w_acc_step[31:0])   : w_acc_step[31:0];
        w_rem32   = r_neg ? (32'd0 - w_acc_step[95:64])  : w_acc_step[95:64];
        w_quo_res = w_word ? sext32(w_quo32) : w_quo64;
        w_rem_res = w_word ? sext32(w_rem32) : w_rem64;
        case (r_op)
            c_alu_mul:                             w_final = w_prod[63:0];
            c_alu_mulh, c_alu_mulhsu, c_alu_mulhu: w_final = w_prod[127:64];
            c_alu_mulw:                            w_final = sext32(w_acc_step[63:32]);
            default:                               w_final = w_rem ? w_rem_res : w_quo_res;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!arst_i) begin
            r_state  <= c_st_idle;
            r_op     <= c_alu_add;
            r_a      <= 64'd0;
            r_b      <= 64'd0;
            r_acc    <= 128'd0;
            r_cnt    <= 7'd0;
            r_neg    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 64'd0;
        end else begin
            r_done <= 1'b0;
            if (flush_i) begin
                r_state <= c_st_idle;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start_i) begin
                            r_op    <= alu_control_i;
                            r_a     <= src1_i;
                            r_b     <= src2_i;
                            r_state <= c_st_prep;
                        end
                    end
                    c_st_prep: begin
                        r_neg <= w_neg_res;
                        r_b   <= w_mag_b;
                        r_cnt <= w_word ? c_iter_word : c_iter_dword;
                        // Word divides park the dividend in [63:32] so its MSB enters first
                        if (w_div) begin
                            r_acc <= w_word ? {64'd0, w_mag_a[31:0], 32'd0} : {64'd0, w_mag_a};
                        end else begin
                            r_acc <= w_word ? {96'd0, w_mag_a[31:0]} : {64'd0, w_mag_a};
                        end
                        if (w_fast) begin
                            r_result <= w_fast_result;
                            r_done   <= 1'b1;
                            r_state  <= c_st_done;
                        end else begin
                            r_state  <= c_st_calc;
                        end
                    end
                    c_st_calc: begin
                        r_acc <= w_acc_step;
                        r_cnt <= w_cnt_dec;
                        if (w_cnt_dec == 7'd0) begin
                            r_result <= w_final;
                            r_done   <= 1'b1;
                            r_state  <= c_st_done;
                        end
                    end
                    c_st_done: begin
                        r_state <= c_st_idle;
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign busy_o   = arst_i && ((r_state == c_st_prep) || (r_state == c_st_calc) ||
                                 ((r_state == c_st_idle) && start_i && !flush_i));
    assign done_o   = r_done;
    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mul_div_unit                                               |
// | Brief    : Directed + random self-checking bench with result scoreboard  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_mul_div_unit;

    localparam logic [4:0] c_op_add    = 5'b00000;
    localparam logic [4:0] c_op_mul    = 5'b01111;
    localparam logic [4:0] c_op_mulh   = 5'b10000;
    localparam logic [4:0] c_op_mulhsu = 5'b10001;
    localparam logic [4:0] c_op_mulhu  = 5'b10010;
    localparam logic [4:0] c_op_div    = 5'b10011;
    localparam logic [4:0] c_op_divu   = 5'b10100;
    localparam logic [4:0] c_op_rem    = 5'b10101;
    localparam logic [4:0] c_op_remu   = 5'b10110;
    localparam logic [4:0] c_op_mulw   = 5'b10111;
    localparam logic [4:0] c_op_divw   = 5'b11000;
    localparam logic [4:0] c_op_divuw  = 5'b11001;
    localparam logic [4:0] c_op_remw   = 5'b11010;
    localparam logic [4:0] c_op_remuw  = 5'b11011;

    logic        clk_i;
    logic        arst_i;
    logic        start_i;
    logic        flush_i;
    logic [4:0]  alu_control_i;
    logic [63:0] src1_i;
    logic [63:0] src2_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] result_o;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    mul_div_unit dut (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .start_i       (start_i),
        .flush_i       (flush_i),
        .alu_control_i (alu_control_i),
        .src1_i        (src1_i),
        .src2_i        (src2_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .result_o      (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference built on native SV operators
    function automatic logic [63:0] ref_model(input logic [4:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        logic [127:0]      p;
        logic signed [63:0] sa, sb;
        logic signed [31:0] sa32, sb32;
        logic [31:0]       r32;
        logic [63:0]       r64;
        logic              ovf64, ovf32;
        sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
        p = '0; r32 = '0; r64 = '0;
        ovf64 = (a == 64'h8000_0000_0000_0000) && (b == {64{1'b1}});
        ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
        case (op)
            c_op_mul:    r64 = a * b;
            c_op_mulh:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r64 = p[127:64]; end
            c_op_mulhsu: begin p = {{64{a[63]}}, a} * {64'd0, b};       r64 = p[127:64]; end
            c_op_mulhu:  begin p = {64'd0, a} * {64'd0, b};             r64 = p[127:64]; end
            c_op_div:    r64 = (b == 0) ? {64{1'b1}} : (ovf64 ? a : 64'(sa / sb));
            c_op_divu:   r64 = (b == 0) ? {64{1'b1}} : a / b;
            c_op_rem:    r64 = (b == 0) ? a : (ovf64 ? 64'd0 : 64'(sa % sb));
            c_op_remu:   r64 = (b == 0) ? a : a % b;
            c_op_mulw:   r32 = a[31:0] * b[31:0];
            c_op_divw:   r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : (ovf32 ? a[31:0] : 32'(sa32 / sb32));
            c_op_divuw:  r32 = (b[31:0] == 0) ? 32'hFFFF_FFFF : a[31:0] / b[31:0];
            c_op_remw:   r32 = (b[31:0] == 0) ? a[31:0] : (ovf32 ? 32'd0 : 32'(sa32 % sb32));
            c_op_remuw:  r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
            default:     r64 = 64'd0;
        endcase
        if (op inside {c_op_mulw, c_op_divw, c_op_divuw, c_op_remw, c_op_remuw})
            r64 = {{32{r32[31]}}, r32};
        return r64;
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        bit word, div, sgn;
        word = op inside {c_op_mulw, c_op_divw, c_op_divuw, c_op_remw, c_op_remuw};
        div  = op inside {c_op_div, c_op_divu, c_op_rem, c_op_remu,
                          c_op_divw, c_op_divuw, c_op_remw, c_op_remuw};
        sgn  = op inside {c_op_div, c_op_rem, c_op_divw, c_op_remw};
        if (op < c_op_mul || op > c_op_remuw) return 2;
        if (div) begin
            if (word ? (b[31:0] == 0) : (b == 0)) return 2;
            if (sgn && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                             : (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}))) return 2;
        end
        return word ? 34 : 66;
    endfunction

    // Issue one op, check busy every cycle, then pop the scoreboard on done_o
    task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int lat);
        int          k;
        logic [63:0] want;
        exp_q.push_back(exp);
        @(negedge clk_i);
        start_i = 1'b1; alu_control_i = op; src1_i = a; src2_i = b;
        #1;
        check({tag, " busy@T"}, 64'(busy_o), 64'd1);
        k = 0;
        while (k < 100 && done_o !== 1'b1) begin
            @(negedge clk_i);
            start_i = 1'b0; alu_control_i = c_op_add; src1_i = ~a; src2_i = ~b;
            #1;
            k++;
            if (done_o !== 1'b1) check({tag, " busy"}, 64'(busy_o), 64'(k < lat));
        end
        want = exp_q.pop_front();
        if (done_o !== 1'b1) begin
            check({tag, " done timeout"}, 64'(k), 64'(lat));
        end else begin
            check({tag, " latency"}, 64'(k), 64'(lat));
            check({tag, " busy@done"}, 64'(busy_o), 64'd0);
            check({tag, " result"}, result_o, want);
            @(negedge clk_i);
            #1;
            check({tag, " done pulse"}, 64'(done_o), 64'd0);
            check({tag, " result hold"}, result_o, want);
        end
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            #1;
            if (done_o === 1'b1) seen++;
        end
        check({tag, " no done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [4:0]  op;
        logic [63:0] a, b;

        arst_i = 1'b0; start_i = 1'b1; flush_i = 1'b0;
        alu_control_i = c_op_mul; src1_i = 64'd7; src2_i = 64'd3;
        repeat (3) @(negedge clk_i);
        #1;
        check("reset busy", 64'(busy_o), 64'd0);
        check("reset done", 64'(done_o), 64'd0);
        check("reset result", result_o, 64'd0);
        @(negedge clk_i);
        arst_i = 1'b1; start_i = 1'b0;

        run_op("mul 7x-3", c_op_mul, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        run_op("mulhu -1x-1", c_op_mulhu, {64{1'b1}}, {64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulh -1x-1", c_op_mulh, {64{1'b1}}, {64{1'b1}}, 64'd0, 66);
        run_op("mulhsu -1x2", c_op_mulhsu, {64{1'b1}}, 64'd2, {64{1'b1}}, 66);
        run_op("div -20/6", c_op_div, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem -20/6", c_op_rem, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("divu 5/0", c_op_divu, 64'd5, 64'd0, {64{1'b1}}, 2);
        run_op("rem 5/0", c_op_rem, 64'd5, 64'd0, 64'd5, 2);
        run_op("div ovf", c_op_div, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000, 2);
        run_op("rem ovf", c_op_rem, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'd0, 2);
        run_op("divuw ffffffff/1", c_op_divuw, 64'h0000_0000_FFFF_FFFF, 64'd1, {64{1'b1}}, 34);
        run_op("remw 7/-2", c_op_remw, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 34);
        run_op("mulw 7fffffffx2", c_op_mulw, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("divw ovf", c_op_divw, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 2);
        run_op("illegal add", c_op_add, 64'd9, 64'd9, 64'd0, 2);
        run_op("illegal 11111", 5'b11111, 64'd9, 64'd9, 64'd0, 2);

        // Flush in the tenth CALC cycle, with a simultaneous start
        @(negedge clk_i);
        start_i = 1'b1; alu_control_i = c_op_mul; src1_i = 64'd11; src2_i = 64'd13;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        flush_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0; start_i = 1'b0;
        #1;
        check("flush busy next", 64'(busy_o), 64'd0);
        expect_no_done("flush calc", 70);

        // Start together with flush in IDLE is not accepted
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; alu_control_i = c_op_divu; src1_i = 64'd50; src2_i = 64'd5;
        #1;
        check("start+flush busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        check("start+flush idle", 64'(busy_o), 64'd0);
        expect_no_done("start+flush", 70);
        run_op("after flush divu", c_op_divu, 64'd1000, 64'd7, 64'd142, 66);

        // Reset in the middle of CALC aborts silently
        @(negedge clk_i);
        start_i = 1'b1; alu_control_i = c_op_div; src1_i = 64'd999; src2_i = 64'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        arst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("midreset busy", 64'(busy_o), 64'd0);
        check("midreset result", result_o, 64'd0);
        arst_i = 1'b1;
        expect_no_done("midreset", 70);
        run_op("after reset remu", c_op_remu, 64'd100, 64'd7, 64'd2, 66);

        for (int i = 0; i < 10; i++) begin
            op = 5'($urandom_range(15, 27));
            a  = {$urandom, $urandom};
            if (i % 3 == 0)      b = 64'($urandom_range(1, 1000));
            else if (i % 3 == 1) b = 64'd0 - 64'($urandom_range(1, 50));
            else                 b = {$urandom, $urandom};
            run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, ref_model(op, a, b), ref_lat(op, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
